// File: rtl/eeprom_axi_pkg.sv
// Shared types and constants for the EEPROM-over-AXI-SPI sequencer: FSM states,
// peripheral register map, STATUS bits, SPI opcodes and the TX byte lists.
package eeprom_axi_pkg;

  typedef enum logic [2:0] {
    ST_CFG,
    ST_IDLE,
    ST_PUSH,
    ST_POLL_BUSY,
    ST_WC_WAIT,
    ST_POLL_RX,
    ST_FETCH,
    ST_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    SEQ_WRITE,
    SEQ_READ,
    SEQ_RDSR
  } seq_kind_e;

  localparam logic [31:0] REG_RX_FIFO = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS  = 32'h0000_0004;
  localparam logic [31:0] REG_COMMAND = 32'h0000_0008;
  localparam logic [31:0] REG_TX_FIFO = 32'h0000_000C;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_RX_EMPTY = 1;
  localparam int STAT_BUSY     = 2;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  localparam int TX_LAST_BIT = 8;

  function automatic logic [2:0] seq_len(seq_kind_e kind);
    case (kind)
      SEQ_WRITE: return 3'd5;
      SEQ_READ:  return 3'd4;
      default:   return 3'd2;
    endcase
  endfunction

  // Word idx of the TX list for a request: bit TX_LAST_BIT ends the CS frame.
  function automatic logic [8:0] seq_word(seq_kind_e kind, logic [2:0] idx,
                                          logic [15:0] addr, logic [7:0] wdata);
    logic [7:0] b;
    logic       last;
    logic [8:0] w;
    b    = 8'h00;
    last = 1'b0;
    case (kind)
      SEQ_WRITE: begin
        case (idx)
          3'd0:    begin b = OP_WREN; last = 1'b1; end
          3'd1:    b = OP_WRITE;
          3'd2:    b = addr[15:8];
          3'd3:    b = addr[7:0];
          default: begin b = wdata; last = 1'b1; end
        endcase
      end
      SEQ_READ: begin
        case (idx)
          3'd0:    b = OP_READ;
          3'd1:    b = addr[15:8];
          3'd2:    b = addr[7:0];
          default: last = 1'b1;
        endcase
      end
      default: begin
        if (idx == 3'd0) b = OP_RDSR;
        else             last = 1'b1;
      end
    endcase
    w = {1'b0, b};
    w[TX_LAST_BIT] = last;
    return w;
  endfunction

endpackage

// File: rtl/axi_lite_single_master.sv
// Performs one AXI-Lite write (AW+W, independent completion) or one read (AR then R)
// per start pulse; done pulses the cycle after the access completes.
module axi_lite_single_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] AWADDR,
  output logic        WVALID,
  input  logic        WREADY,
  output logic [31:0] WDATA,
  output logic        ARVALID,
  input  logic        ARREADY,
  output logic [31:0] ARADDR,
  input  logic        RVALID,
  output logic        RREADY,
  input  logic [31:0] RDATA
);

  logic        aw_vld_q, aw_vld_d, w_vld_q, w_vld_d;
  logic        ar_vld_q, ar_vld_d, rready_q, rready_d;
  logic        done_q, done_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic [31:0] rdata_q, rdata_d;

  assign busy = aw_vld_q | w_vld_q | ar_vld_q | rready_q;

  always_comb begin
    aw_vld_d = aw_vld_q;
    w_vld_d  = w_vld_q;
    ar_vld_d = ar_vld_q;
    rready_d = rready_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    araddr_d = araddr_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    if (start && !busy) begin
      if (is_write) begin
        aw_vld_d = 1'b1;
        w_vld_d  = 1'b1;
        awaddr_d = addr;
        wdata_d  = wdata;
      end else begin
        ar_vld_d = 1'b1;
        araddr_d = addr;
      end
    end
    if (aw_vld_q && AWREADY) aw_vld_d = 1'b0;
    if (w_vld_q && WREADY)   w_vld_d  = 1'b0;
    // The write is complete once neither channel is still waiting for READY.
    if ((aw_vld_q || w_vld_q) && !(aw_vld_q && !AWREADY) && !(w_vld_q && !WREADY))
      done_d = 1'b1;
    if (ar_vld_q && ARREADY) begin
      ar_vld_d = 1'b0;
      rready_d = 1'b1;
    end
    if (rready_q && RVALID) begin
      rready_d = 1'b0;
      rdata_d  = RDATA;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_vld_q <= 1'b0;
      w_vld_q  <= 1'b0;
      ar_vld_q <= 1'b0;
      rready_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      araddr_q <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      aw_vld_q <= aw_vld_d;
      w_vld_q  <= w_vld_d;
      ar_vld_q <= ar_vld_d;
      rready_q <= rready_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      araddr_q <= araddr_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
    end
  end

  assign AWVALID = aw_vld_q;
  assign AWADDR  = awaddr_q;
  assign WVALID  = w_vld_q;
  assign WDATA   = wdata_q;
  assign ARVALID = ar_vld_q;
  assign ARADDR  = araddr_q;
  assign RREADY  = rready_q;
  assign done    = done_q;
  assign rdata   = rdata_q;

endmodule

// File: rtl/eeprom_axi_sequencer.sv
// Sequences single-byte EEPROM writes/reads through the AXI_SPI_top register map.
// Optional macro EEPROM_WIP_POLL_EN: poll RDSR WIP instead of a fixed write-cycle wait.
module eeprom_axi_sequencer
  import eeprom_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter logic [31:0] CMD_WORD  = 32'h3000_0000,
  parameter int          WC_CYCLES = 500000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] AWADDR,
  output logic        WVALID,
  input  logic        WREADY,
  output logic [31:0] WDATA,
  output logic        ARVALID,
  input  logic        ARREADY,
  output logic [31:0] ARADDR,
  input  logic        RVALID,
  output logic        RREADY,
  input  logic [31:0] RDATA
);

  localparam logic [19:0] WC_LAST = 20'(WC_CYCLES - 1);

  seq_state_e  state_q, state_d;
  seq_kind_e   kind_q, kind_d;
  logic        wait_q, wait_d, push_wr_q, push_wr_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic [19:0] wc_q, wc_d;
  logic        req_ready_q, req_ready_d, done_q, done_d;

  logic        m_start, m_is_write, m_busy, m_done;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        unused_m;

  assign unused_m = m_busy ^ (^m_rdata[31:8]);

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    wait_d     = wait_q;
    push_wr_d  = push_wr_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wc_d       = wc_q;
    m_start    = 1'b0;
    m_is_write = 1'b0;
    m_addr     = BASE_ADDR + REG_STATUS;
    m_wdata    = '0;
    case (state_q)
      ST_CFG: begin
        m_is_write = 1'b1;
        m_addr     = BASE_ADDR + REG_COMMAND;
        m_wdata    = CMD_WORD;
        if (!wait_q) begin
          m_start = 1'b1;
          wait_d  = 1'b1;
        end else if (m_done) begin
          wait_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          kind_d    = req_write ? SEQ_WRITE : SEQ_READ;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          idx_d     = 3'd0;
          push_wr_d = 1'b0;
          state_d   = ST_PUSH;
        end
      end
      ST_PUSH: begin
        // Alternate STATUS check and TX FIFO write; a full FIFO repeats the check.
        if (push_wr_q) begin
          m_is_write = 1'b1;
          m_addr     = BASE_ADDR + REG_TX_FIFO;
          m_wdata    = {23'd0, seq_word(kind_q, idx_q, addr_q, wdata_q)};
        end
        if (!wait_q) begin
          m_start = 1'b1;
          wait_d  = 1'b1;
        end else if (m_done) begin
          wait_d = 1'b0;
          if (!push_wr_q) begin
            push_wr_d = !m_rdata[STAT_TX_FULL];
          end else begin
            push_wr_d = 1'b0;
            if (idx_q == seq_len(kind_q) - 3'd1) begin
              idx_d   = 3'd0;
              state_d = (kind_q == SEQ_WRITE) ? ST_POLL_BUSY : ST_POLL_RX;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end
      ST_POLL_BUSY: begin
        if (!wait_q) begin
          m_start = 1'b1;
          wait_d  = 1'b1;
        end else if (m_done) begin
          wait_d = 1'b0;
          if (!m_rdata[STAT_BUSY]) begin
`ifdef EEPROM_WIP_POLL_EN
            kind_d  = SEQ_RDSR;
            idx_d   = 3'd0;
            state_d = ST_PUSH;
`else
            wc_d    = '0;
            state_d = (WC_CYCLES == 0) ? ST_DONE : ST_WC_WAIT;
`endif
          end
        end
      end
      ST_WC_WAIT: begin
`ifdef EEPROM_WIP_POLL_EN
        state_d = ST_DONE;
`else
        if (wc_q == WC_LAST) state_d = ST_DONE;
        else                 wc_d    = wc_q + 20'd1;
`endif
      end
      ST_POLL_RX: begin
        if (!wait_q) begin
          m_start = 1'b1;
          wait_d  = 1'b1;
        end else if (m_done) begin
          wait_d = 1'b0;
          if (!m_rdata[STAT_RX_EMPTY]) state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        m_addr = BASE_ADDR + REG_RX_FIFO;
        if (!wait_q) begin
          m_start = 1'b1;
          wait_d  = 1'b1;
        end else if (m_done) begin
          wait_d = 1'b0;
          // A status poll only steers the FSM; rdata keeps the last read byte.
          if (kind_q == SEQ_RDSR) begin
            if (m_rdata[0]) begin
              idx_d   = 3'd0;
              state_d = ST_PUSH;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            rdata_d = m_rdata[7:0];
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_CFG;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= ST_CFG;
      kind_q      <= SEQ_WRITE;
      wait_q      <= 1'b0;
      push_wr_q   <= 1'b0;
      idx_q       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wc_q        <= '0;
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      wait_q      <= wait_d;
      push_wr_q   <= push_wr_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      wc_q        <= wc_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign done      = done_q;
  assign rdata     = rdata_q;

  axi_lite_single_master u_master (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .start    (m_start),
    .is_write (m_is_write),
    .addr     (m_addr),
    .wdata    (m_wdata),
    .busy     (m_busy),
    .done     (m_done),
    .rdata    (m_rdata),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .AWADDR   (AWADDR),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .WDATA    (WDATA),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .ARADDR   (ARADDR),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .RDATA    (RDATA)
  );

endmodule

// File: tb/tb_eeprom_axi_sequencer.sv
// Bench for eeprom_axi_sequencer with an AXI_SPI_top slave stub and EEPROM byte model.
module tb_eeprom_axi_sequencer;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          WC   = 16;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        req_valid, req_ready, req_write, done;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, rdata;
  logic        AWVALID, AWREADY, WVALID, WREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;

  always #5 ACLK = ~ACLK;

  eeprom_axi_sequencer #(.BASE_ADDR(BASE), .CMD_WORD(32'h3000_0000), .WC_CYCLES(WC)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA)
  );

  // ---------------- slave stub state ----------------
  logic [31:0] tx_log[$];
  logic [31:0] cmd_log[$];
  logic [7:0]  frame[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  mem[int];
  logic        aw_got = 1'b0, w_got = 1'b0, wel = 1'b0, tx_ok = 1'b0;
  logic [31:0] aw_addr_l, w_data_l;
  int          aw_block = 0, stall_seen = 0, stall_req = 0;
  int          full_req = 0, full_given = 0, busy_left = 0;
  int          dup_err = 0, order_err = 0, other_wr = 0, busy0_cyc = 0;
  int          cyc = 0, done_cnt = 0, stab_err = 0, drop_err = 0, overlap_err = 0;

  assign AWREADY = AWVALID && (aw_block == 0) && (stall_req == stall_seen);
  assign WREADY  = WVALID;
  assign ARREADY = ARVALID;

  function automatic logic [7:0] rd_mem(int k);
    return mem.exists(k) ? mem[k] : 8'h00;
  endfunction

  function automatic void slave_write(logic [31:0] a, logic [31:0] d);
    if (a == BASE + 32'h8) begin
      cmd_log.push_back(d);
    end else if (a == BASE + 32'hC) begin
      if (!tx_ok) order_err++;
      tx_ok = 1'b0;
      tx_log.push_back(d);
      frame.push_back(d[7:0]);
      if (d[8]) begin
        case (frame[0])
          8'h06: wel = 1'b1;
          8'h02: if (wel && frame.size() >= 4) begin
                   mem[int'({frame[1], frame[2]})] = frame[3];
                   wel = 1'b0;
                   busy_left = 3;
                 end
          8'h03: if (frame.size() >= 4) rx_q.push_back(rd_mem(int'({frame[1], frame[2]})));
          8'h05: rx_q.push_back(8'h00);
          default: ;
        endcase
        frame.delete();
      end
    end else begin
      other_wr++;
    end
  endfunction

  function automatic logic [31:0] slave_read(logic [31:0] a);
    logic full, bsy;
    if (a == BASE + 32'h4) begin
      full = (full_given < full_req);
      if (full) full_given++;
      tx_ok = !full;
      bsy = (busy_left > 0);
      if (bsy) busy_left--;
      else     busy0_cyc = cyc;
      return {29'd0, bsy, (rx_q.size() == 0), full};
    end else if (a == BASE && rx_q.size() > 0) begin
      return {24'd0, rx_q.pop_front()};
    end
    return 32'd0;
  endfunction

  always @(posedge ACLK) begin
    logic ga, gw;
    if (!ARESETn) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_block <= 0;
      RVALID   <= 1'b0;
      RDATA    <= 32'd0;
      frame.delete();
      rx_q.delete();
      busy_left = 0;
      tx_ok = 1'b0;
      wel = 1'b0;
    end else begin
      if (AWVALID && AWREADY) begin
        if (aw_got) dup_err++;
        aw_addr_l = AWADDR;
      end
      if (WVALID && WREADY) begin
        if (w_got) dup_err++;
        w_data_l = WDATA;
      end
      ga = aw_got || (AWVALID && AWREADY);
      gw = w_got || (WVALID && WREADY);
      if (stall_req != stall_seen && AWVALID) begin
        aw_block   <= 4;
        stall_seen <= stall_req;
      end else if (aw_block > 0 && AWVALID && gw) begin
        aw_block <= aw_block - 1;
      end
      if (ga && gw) begin
        slave_write(aw_addr_l, w_data_l);
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= ga;
        w_got  <= gw;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        RDATA  <= slave_read(ARADDR);
      end
    end
  end

  // ---------------- protocol monitor ----------------
  logic        p_aw_pend = 1'b0, p_w_pend = 1'b0, p_aw_hs = 1'b0, p_w_hs = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0;

  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (ARESETn) begin
      if (done) done_cnt++;
      if (p_aw_pend && (!AWVALID || AWADDR != p_awaddr)) stab_err++;
      if (p_w_pend && (!WVALID || WDATA != p_wdata)) stab_err++;
      if (p_aw_hs && AWVALID) drop_err++;
      if (p_w_hs && WVALID) drop_err++;
      if ((AWVALID || WVALID) && (ARVALID || RREADY)) overlap_err++;
    end
    p_aw_pend = ARESETn && AWVALID && !AWREADY;
    p_w_pend  = ARESETn && WVALID && !WREADY;
    p_aw_hs   = ARESETn && AWVALID && AWREADY;
    p_w_hs    = ARESETn && WVALID && WREADY;
    p_awaddr  = AWADDR;
    p_wdata   = WDATA;
  end

  // ---------------- checking ----------------
  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input logic cond, input int act);
    total++;
    if (!cond) begin
      bad++;
      $display("FAIL %s: got %0d", name, act);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    check({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_req(input logic wr, input logic [15:0] a, input logic [7:0] d,
                         output logic ok, output logic [7:0] rd, output int dcyc);
    int n;
    @(negedge ACLK);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(posedge ACLK);
    #1;
    req_valid = 1'b0;
    ok = 1'b0;
    rd = 8'h00;
    dcyc = 0;
    n = 0;
    while (!ok && n < 4000) begin
      @(negedge ACLK);
      if (done) begin
        ok = 1'b1;
        rd = rdata;
        dcyc = cyc;
      end
      n++;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          n;
    logic [31:0] w[5];
    logic [7:0]  rd;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [15:0] a, logic [7:0] d, int n,
                              logic [31:0] w0, logic [31:0] w1, logic [31:0] w2,
                              logic [31:0] w3, logic [31:0] w4, logic [7:0] rd);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.n = n; v.rd = rd;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
    return v;
  endfunction

  // Runs one request and checks TX byte list, done count, rdata and write-cycle wait.
  task automatic run_and_check(input string name, input vec_t v);
    int          base, d0, dcyc;
    logic        ok;
    logic [7:0]  rd, rprev;
    base  = tx_log.size();
    d0    = done_cnt;
    rprev = rdata;
    run_req(v.wr, v.addr, v.wdata, ok, rd, dcyc);
    check({name, " done"}, {31'd0, ok}, 32'd1);
    check({name, " tx count"}, tx_log.size() - base, v.n);
    for (int k = 0; k < v.n; k++)
      check($sformatf("%s tx word %0d", name, k),
            (base + k < tx_log.size()) ? tx_log[base + k] : 32'hDEAD_BEEF, v.w[k]);
    if (v.wr) begin
      check({name, " rdata hold"}, {24'd0, rd}, {24'd0, rprev});
      check({name, " eeprom byte"}, {24'd0, rd_mem(int'(v.addr))}, {24'd0, v.wdata});
      check_true({name, " wc wait"}, (dcyc - busy0_cyc >= WC) && (dcyc - busy0_cyc <= WC + 8),
                 dcyc - busy0_cyc);
    end else begin
      check({name, " rdata"}, {24'd0, rd}, {24'd0, v.rd});
    end
    repeat (2) @(negedge ACLK);
    check({name, " one done"}, done_cnt - d0, 32'd1);
    check({name, " ready again"}, {31'd0, req_ready}, 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    int         base, d0, nfull, cbase, n;
    logic       ok;
    logic [7:0] rd;
    int         dcyc;

    vecs[0] = mk(1'b1, 16'h00F0, 8'hAA, 5, 32'h106, 32'h002, 32'h000, 32'h0F0, 32'h1AA, 8'h00);
    vecs[1] = mk(1'b0, 16'h00F0, 8'h00, 4, 32'h003, 32'h000, 32'h0F0, 32'h100, 32'h0,   8'hAA);
    vecs[2] = mk(1'b1, 16'h1234, 8'h5C, 5, 32'h106, 32'h002, 32'h012, 32'h034, 32'h15C, 8'h00);
    vecs[3] = mk(1'b0, 16'h1234, 8'h00, 4, 32'h003, 32'h012, 32'h034, 32'h100, 32'h0,   8'h5C);
    vecs[4] = mk(1'b0, 16'h00F0, 8'h00, 4, 32'h003, 32'h000, 32'h0F0, 32'h100, 32'h0,   8'hAA);

    ARESETn = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst valids", {28'd0, AWVALID, WVALID, ARVALID, RREADY}, 32'd0);
    check("rst awaddr", AWADDR, 32'd0);
    check("rst wdata", WDATA, 32'd0);
    check("rst araddr", ARADDR, 32'd0);
    check("rst outs", {22'd0, req_ready, done, rdata}, 32'd0);

    ARESETn = 1'b1;
    wait_ready("cfg");
    check("cfg write count", cmd_log.size(), 32'd1);
    check("cfg word", (cmd_log.size() > 0) ? cmd_log[0] : 32'hDEAD_BEEF, 32'h3000_0000);
    check("stray writes", other_wr, 32'd0);

    for (int i = 0; i < 5; i++) run_and_check($sformatf("vec%0d", i), vecs[i]);

    // AW stalls after W completed: AWADDR must hold, W must not be resent.
    stall_req = stall_req + 1;
    run_and_check("awstall", mk(1'b1, 16'h0010, 8'h33, 5,
                  32'h106, 32'h002, 32'h000, 32'h010, 32'h133, 8'h00));

    // TX FIFO reported full for 10 STATUS reads.
    nfull = full_given;
    full_req = full_req + 10;
    run_and_check("txfull", mk(1'b1, 16'h0020, 8'h44, 5,
                  32'h106, 32'h002, 32'h000, 32'h020, 32'h144, 8'h00));
    check("txfull reads", full_given - nfull, 32'd10);

    // A request offered while busy is dropped.
    base = tx_log.size();
    d0 = done_cnt;
    fork
      run_req(1'b1, 16'h0030, 8'h77, ok, rd, dcyc);
      begin
        repeat (6) @(negedge ACLK);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040;
        @(negedge ACLK);
        req_valid = 1'b0;
      end
    join
    repeat (30) @(negedge ACLK);
    check("ignored req done", {31'd0, ok}, 32'd1);
    check("ignored req tx", tx_log.size() - base, 32'd5);
    check("ignored req dones", done_cnt - d0, 32'd1);

    // Reset for one cycle in the middle of PUSH.
    base = tx_log.size();
    cbase = cmd_log.size();
    d0 = done_cnt;
    @(negedge ACLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0050; req_wdata = 8'h99;
    @(negedge ACLK);
    req_valid = 1'b0;
    n = 0;
    while (tx_log.size() < base + 2 && n < 500) begin
      @(negedge ACLK);
      n++;
    end
    check_true("mid push reached", n < 500, n);
    ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    check("midrst valids", {28'd0, AWVALID, WVALID, ARVALID, RREADY}, 32'd0);
    check("midrst ready/done", {30'd0, req_ready, done}, 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    wait_ready("midrst");
    check("midrst cfg rewrite", cmd_log.size() - cbase, 32'd1);
    check("midrst no done", done_cnt - d0, 32'd0);
    check("midrst no write", {24'd0, rd_mem(16'h0050)}, 32'd0);
    run_and_check("post rst read", mk(1'b0, 16'h0010, 8'h00, 4,
                  32'h003, 32'h000, 32'h010, 32'h100, 32'h0, 8'h33));

    check("tx order errors", order_err, 32'd0);
    check("dup handshakes", dup_err, 32'd0);
    check("valid stability", stab_err, 32'd0);
    check("valid drop", drop_err, 32'd0);
    check("aw/ar overlap", overlap_err, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
